// File: rtl/alu_pipe.sv
// EX-stage ALU with valid/ready in and out ports, a one-entry output register
// and an iterative radix-2 shift-add multiplier for MUL/MULHU.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_hi;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_overflow;
  logic               r_illegal;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic               w_alu_ill;
  logic               w_is_mul;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_prod_half;
  logic               w_last;
  logic               w_slot_free;

  // Handshake: a transfer happens on any rising edge where valid & ready are
  // both high; valid never depends on ready, and in_ready never on in_valid.
  assign w_slot_free = ~r_out_valid | out_ready;
  assign in_ready    = (r_state == S_IDLE) & w_slot_free;
  assign busy        = (r_state == S_BUSY);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign carry       = r_carry;
  assign overflow    = r_overflow;
  assign illegal     = r_illegal;

  assign w_sum    = {1'b0, dataa} + {1'b0, datab};
  assign w_diff   = {1'b0, dataa} - {1'b0, datab};
  assign w_shamt  = datab[SHW-1:0];
  assign w_is_mul = (op == 4'b1100) | (op == 4'b1101);

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_ill = 1'b0;
    case (op)
      4'b0000: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (dataa[WIDTH-1] == datab[WIDTH-1]) & (w_sum[WIDTH-1] != dataa[WIDTH-1]);
      end
      4'b0001: w_alu_res = {{(WIDTH-1){1'b0}}, (dataa < datab)};
      4'b0010: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (dataa[WIDTH-1] != datab[WIDTH-1]) & (w_diff[WIDTH-1] != dataa[WIDTH-1]);
      end
      4'b0011: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataa) < $signed(datab))};
      4'b0100: w_alu_res = dataa & datab;
      4'b0101: w_alu_res = dataa | datab;
      4'b0110: w_alu_res = ~(dataa | datab);
      4'b0111: w_alu_res = dataa ^ datab;
      4'b1000: w_alu_res = dataa << w_shamt;
      4'b1001: w_alu_res = $signed(dataa) >>> w_shamt;
      4'b1010: w_alu_res = dataa >> w_shamt;
      4'b1100, 4'b1101: w_alu_res = '0;
      default: w_alu_ill = 1'b1;
    endcase
  end

  // One multiply step; the last step's sum is written straight to the output.
  assign w_step      = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod_half = r_hi ? w_step[2*WIDTH-1:WIDTH] : w_step[WIDTH-1:0];
  assign w_last      = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_hi        <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (r_out_valid & out_ready) r_out_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (in_valid & in_ready) begin
          if (w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, dataa};
            r_mplier <= datab;
            r_acc    <= '0;
            r_hi     <= op[0];
            r_cnt    <= CW'(WIDTH);
            r_state  <= S_BUSY;
          end else begin
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_carry     <= w_alu_c;
            r_overflow  <= w_alu_v;
            r_illegal   <= w_alu_ill;
            r_out_valid <= 1'b1;
          end
        end
      end else begin
        if (!w_last) begin
          r_acc    <= w_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
        end else if (w_slot_free) begin
          // Final step is held off while an older result still occupies the slot.
          r_result    <= w_prod_half;
          r_zero      <= (w_prod_half == '0);
          r_carry     <= 1'b0;
          r_overflow  <= 1'b0;
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a reference model fills an expected queue at each accept
// and a negedge monitor checks every popped result against it.
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         illegal;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W+3:0] exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dataa(dataa), .datab(datab), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .illegal(illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Packed as {illegal, overflow, carry, zero, result}.
  function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    logic           c, v, il;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (o)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                  v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'd1: r = (a < b) ? 1 : 0;
      4'd2: begin r = a - b; c = (a < b); v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'd3: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = ~(a | b);
      4'd7: r = a ^ b;
      4'd8: r = a << b[4:0];
      4'd9: r = $signed(a) >>> b[4:0];
      4'd10: r = a >> b[4:0];
      4'd12: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
      4'd13: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
      default: il = 1'b1;
    endcase
    return {il, v, c, (r == '0), r};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h expected none", result);
      end else begin
        logic [W+3:0] e;
        e = exp_q.pop_front();
        if ({illegal, overflow, carry, zero, result} !== e) begin
          errors++;
          $display("FAIL output got=%h expected=%h", {illegal, overflow, carry, zero, result}, e);
        end
      end
    end
  end

  // Entered and left at posedge+1; the accept edge is the posedge inside.
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; op = o; dataa = a; datab = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
    end else begin
      exp_q.push_back(model(o, a, b));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; dataa = '0; datab = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, result, zero, carry, overflow, illegal, busy, in_ready} !== {1'b0, {W{1'b0}}, 5'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got ov=%b res=%h z=%b c=%b v=%b il=%b busy=%b rdy=%b expected all 0 rdy=1",
               out_valid, result, zero, carry, overflow, illegal, busy, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    out_ready = 1'b1;
    send(4'd0, 32'hFFFF_FFFF, 32'h1);
    send(4'd0, 32'h7FFF_FFFF, 32'h1);
    send(4'd2, 32'd3, 32'd5);
    send(4'd2, 32'h8000_0000, 32'h1);
    send(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF);
    send(4'd6, 32'h1234_5678, 32'h0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_shift_cmp;
    out_ready = 1'b1;
    send(4'd9, 32'h8000_0000, 32'd4);
    send(4'd10, 32'h8000_0000, 32'd4);
    send(4'd8, 32'h1, 32'h21);
    send(4'd3, 32'hFFFF_FFFF, 32'h1);
    send(4'd1, 32'hFFFF_FFFF, 32'h1);
    send(4'd9, 32'h4000_0000, 32'd31);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int c0;
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++) send(4'd0, $urandom, $urandom);
    checks++;
    if (cyc - c0 != 10) begin
      errors++;
      $display("FAIL back_to_back cycles=%0d expected 10", cyc - c0);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [W+3:0] ea;
    out_ready = 1'b0;
    ea = model(4'd7, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
    send(4'd7, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
    in_valid = 1'b1; op = 4'd0; dataa = 32'd100; datab = 32'd23;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== ea[W-1:0]) begin
        errors++;
        $display("FAIL stall_hold rdy=%b ov=%b res=%h expected rdy=0 ov=1 res=%h",
                 in_ready, out_valid, result, ea[W-1:0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd0, 32'd100, 32'd23);
    send(4'd5, 32'h0000_FF00, 32'h00FF_0000);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_mul(input logic [3:0] o);
    int j;
    logic hold_ok;
    out_ready = 1'b1;
    hold_ok = 1'b1;
    send(o, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    j = 0;
    @(negedge clk);
    while (!out_valid && j < 100) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
      j++;
      @(negedge clk);
    end
    checks++;
    if (j != 32) begin
      errors++;
      $display("FAIL mul_latency op=%h cycles=%0d expected 32", o, j);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL mul_busy op=%h busy/in_ready not 1/0 throughout expected busy=1 rdy=0", o);
    end
    @(posedge clk); #1;
    repeat (1) @(posedge clk); #1;
  endtask

  task automatic test_mul_stall;
    int first;
    logic stable_ok;
    logic [W+3:0] em;
    em = model(4'd12, 32'h0001_0003, 32'h0002_0005);
    stable_ok = 1'b1;
    first = -1;
    out_ready = 1'b0;
    send(4'd0, 32'd7, 32'd9);
    in_valid = 1'b1; op = 4'd12; dataa = 32'h0001_0003; datab = 32'h0002_0005;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd12, 32'h0001_0003, 32'h0002_0005);
    out_ready = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid && first < 0) first = j;
      if (out_valid && result !== em[W-1:0]) stable_ok = 1'b0;
    end
    checks++;
    if (first != 32) begin
      errors++;
      $display("FAIL mul_stall_latency first=%0d expected 32", first);
    end
    checks++;
    if (!stable_ok || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mul_stall_hold ov=%b res=%h expected ov=1 res=%h", out_valid, result, em[W-1:0]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mul;
    logic stale;
    stale = 1'b0;
    out_ready = 1'b1;
    send(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mul busy=%b ov=%b rdy=%b expected 0 0 1", busy, out_valid, in_ready);
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL reset_mul_stale out_valid=1 expected 0 after reset");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    send(4'b1111, $urandom, $urandom);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || zero !== 1'b1 || result !== '0) begin
      errors++;
      $display("FAIL illegal_latency ov=%b il=%b z=%b res=%h expected 1 1 1 0",
               out_valid, illegal, zero, result);
    end
    @(posedge clk); #1;
    send(4'b1011, 32'hFFFF_FFFF, 32'h1);
    send(4'b1110, 32'h5, 32'h6);
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_shift_cmp();
    test_back_to_back();
    test_backpressure();
    test_mul(4'd12);
    test_mul(4'd13);
    test_mul_stall();
    test_reset_mul();
    test_illegal();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lost_results pending=%0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the MIPS datapath ALU. It takes one operation per cycle through a valid/ready input port and returns a registered result with status flags through a valid/ready output port. Single-cycle operations have one-cycle latency. It adds signed/unsigned compare ops and an iterative shift-add multiplier (`MUL`/`MULHU`) that holds the unit busy for WIDTH cycles. It sits in the EX stage; the pipeline controller stalls on `in_ready` low.

## Interface
- `WIDTH`, default 32: datapath width. Must be a power of two and at least 4. `SHW = log2(WIDTH)` is derived internally.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted on an edge where `in_valid & in_ready`.
- `op`  in  4  operation code (see Operation).
- `dataa`  in  WIDTH  operand A.
- `datab`  in  WIDTH  operand B; only `datab[SHW-1:0]` is used for shifts.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes the result on an edge where `out_valid & out_ready`.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`.
- `carry`  out  1  ADD: carry-out; SUB: borrow (`dataa < datab` unsigned); 0 for all other ops.
- `overflow`  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- `illegal`  out  1  the op code was unassigned.
- `busy`  out  1  a multiply is in progress.

## Operation
- Op codes:
  - ADD 0000, SLTU 0001, SUB 0010, SLT 0011
  - AND 0100, OR 0101, NOR 0110, XOR 0111
  - SLL 1000, SRA 1001, SRL 1010
  - MUL 1100, MULHU 1101
  - All other codes are illegal.
- SLT/SLTU: `result = {WIDTH-1 zeros, (A<B)}`, signed or unsigned compare respectively.
- Shifts use the shift amount `datab[SHW-1:0]`.
  - SRA fills with `dataa[WIDTH-1]`.
  - SRL fills with 0.
- Illegal op: `result = 0`, `zero = 1`, `illegal = 1`. It still completes with one-cycle latency. The result is never X.
- MUL/MULHU: unsigned radix-2 shift-add producing a 2·WIDTH-bit product.
  - MUL returns the low WIDTH bits; MULHU returns the high WIDTH bits.
  - Flags: `carry = 0`, `overflow = 0`, `zero` computed from the returned half.
- States:
  - **IDLE**
    - Accepting a single-cycle op writes `result`/flags and sets `out_valid`; the state stays IDLE.
    - Accepting MUL/MULHU latches the operands, the op and `cnt = WIDTH`, and goes to BUSY. The accept edge does not change `out_valid`.
  - **BUSY**
    - Each edge performs one step: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplier right and decrement `cnt`.
    - On the edge where `cnt` goes from 1 to 0: write the product half, set `out_valid`, return to IDLE.
    - If `out_valid` is still high from an earlier result, the final step is withheld. The state stays BUSY with `cnt = 1` until the output slot frees.
- Output register:
  - Holds one entry.
  - While `out_valid & ~out_ready`, `result` and all flags are held stable.
  - `out_valid` clears on a pop edge unless a new result is written on that same edge.
- `in_ready = (state == IDLE) & (~out_valid | out_ready)`.
  - Pop and accept may occur on the same edge, giving one op per cycle for single-cycle ops.
  - `in_ready` is low for the whole of BUSY.
- `busy = (state == BUSY)`.
- Reset:
  - Forces IDLE, `cnt = 0`, `out_valid = 0`, and `result`, `zero`, `carry`, `overflow`, `illegal` all 0.
  - A reset during BUSY discards the multiply and produces no output.
- Operand and op values offered while `in_ready` is low are ignored.

## Timing
- Single-cycle op accepted at edge N: `out_valid = 1` in the cycle after edge N (latency 1).
- MUL accepted at edge N with no back-pressure:
  - `busy` is high from after edge N until edge N+WIDTH.
  - `out_valid` rises after edge N+WIDTH (latency WIDTH).
  - `in_ready` is low until then.
- Back-pressure on a single-cycle op: `in_ready` drops in the same cycle as `out_valid & ~out_ready`. No input is lost or duplicated.
- All outputs are registered except `in_ready`, which is combinational from state, `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- **Reset and single-cycle ALU ops.**
  - After reset, every output is 0 and `in_ready = 1`.
  - ADD `0xFFFFFFFF` + `1`: result 0, `zero = 1`, `carry = 1`, `overflow = 0`.
  - ADD `0x7FFFFFFF` + `1`: result `0x80000000`, `overflow = 1`.
  - SUB `3 - 5`: result `0xFFFFFFFE`, `carry = 1`.
- **Shifts and compares.**
  - SRA `0x80000000` by 4: result `0xF8000000`.
  - SRL `0x80000000` by 4: result `0x08000000`.
  - SLL `1` with `datab = 0x21`: result `0x2` (only the low 5 bits are used).
  - SLT `0xFFFFFFFF` vs `1`: result 1.
  - SLTU `0xFFFFFFFF` vs `1`: result 0.
- **Throughput and back-pressure.**
  - Ten back-to-back ADDs with `out_ready = 1`: one result per cycle, all in order.
  - Hold `out_ready = 0` for 3 cycles: result stable, `in_ready = 0`, no op dropped.
- **Multiply.**
  - MUL `0xFFFFFFFF × 0xFFFFFFFF`: `out_valid` exactly 32 cycles after accept, result `0x00000001`.
  - MULHU on the same operands: result `0xFFFFFFFE`.
  - `busy = 1` and `in_ready = 0` throughout.
- **Multiply while the output is stalled.**
  - MUL accepted on the pop edge of a prior result, with `out_ready` low until cycle 40.
  - Product delivered only after the pop; the prior result is not overwritten.
- **Reset and illegal op.**
  - Assert `rst` at cycle 10 of a MUL: IDLE, `out_valid = 0`, no stale product appears afterwards.
  - Op `1111`: result 0, `illegal = 1`, `zero = 1`, latency 1.
